// File: rtl/apb_pkg.sv
// Shared APB widths, FSM state encoding and command/response records.
// Used by the command master and by the APB slave blocks.
package apb_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // Reads must present zero write data and strobes on the bus.
  function automatic apb_cmd_t apb_cmd_norm(input apb_cmd_t c);
    apb_cmd_t n;
    n = c;
    if (!c.write) begin
      n.wdata = '0;
      n.strb  = '0;
    end
    return n;
  endfunction

endpackage

// File: rtl/apb_cmd_master.sv
// APB4 requester, one command in flight; `APB_TIMEOUT_EN adds an ACCESS-stall abort.
// Latency: accept N, SETUP N+1, ACCESS N+2.., rsp_valid N+3 with a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  input  logic [APB_STRB_W-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [APB_STRB_W-1:0] pstrb,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e state_q, state_d;
  apb_cmd_t   cmd_in, cmd_q;
  apb_rsp_t   rsp_q;
  logic       ready_q;
  logic       tmo;

  assign cmd_in = {cmd_addr, cmd_write, cmd_wdata, cmd_strb};

`ifdef APB_TIMEOUT_EN
  logic [15:0] wait_cnt_q;

  // Counts earlier pready=0 ACCESS cycles; fires on the TIMEOUT_CYCLES-th one.
  assign tmo = (state_q == ACCESS) && !pready &&
               (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS && !pready) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid && ready_q) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || tmo) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      // Registered so cmd_ready stays low while reset is held.
      ready_q <= (state_d == IDLE);
      if (state_q == IDLE && cmd_valid && ready_q) begin
        cmd_q <= apb_cmd_norm(cmd_in);
      end
      if (state_q == ACCESS && pready) begin
        rsp_q.rdata   <= cmd_q.write ? '0 : prdata;
        rsp_q.err     <= pslverr;
        rsp_q.timeout <= 1'b0;
      end else if (tmo) begin
        rsp_q.rdata   <= '0;
        rsp_q.err     <= 1'b1;
        rsp_q.timeout <= 1'b1;
      end
    end
  end

  assign cmd_ready   = ready_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

  assign psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign penable = (state_q == ACCESS);
  assign paddr   = cmd_q.addr;
  assign pwrite  = cmd_q.write;
  assign pwdata  = cmd_q.wdata;
  assign pstrb   = cmd_q.strb;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed commands, APB slave model, response scoreboard.
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int TMO = 4;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;
  apb_rsp_t exp_q[$];

  task automatic chk(input string tag, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: actual 0x%0h required 0x%0h", tag, name, act, req);
    end
  endtask

  // Slave model: wait states then pready; junk on pready/pslverr/prdata elsewhere.
  int          slv_wait = 0;
  bit          slv_hang = 1'b0;
  logic [31:0] slv_rdata = '0;
  bit          slv_err = 1'b0;
  int          acc_n = 0;

  always @(negedge sys_clk) begin
    if (psel && penable) begin
      acc_n   = acc_n + 1;
      pready  = !slv_hang && (acc_n == slv_wait + 1);
      prdata  = pready ? slv_rdata : 32'hBAD0_0000 + 32'(acc_n);
      pslverr = pready ? slv_err : 1'b1;
    end else begin
      acc_n   = 0;
      pready  = 1'b1;
      prdata  = 32'hDEAD_BEEF;
      pslverr = 1'b1;
    end
  end

  // Monitor: pops expected response on each handshake, checks hold while stalled.
  bit       held_vld = 1'b0;
  apb_rsp_t held;

  always begin : monitor
    apb_rsp_t cur;
    apb_rsp_t ex;
    @(negedge sys_clk);
    #1;
    if (rst) begin
      held_vld = 1'b0;
    end else if (rsp_valid) begin
      cur = {rsp_rdata, rsp_err, rsp_timeout};
      if (held_vld) chk("mon", "rsp_stable", 64'(cur), 64'(held));
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL mon.unexpected_rsp: actual rdata 0x%0h required no response", rsp_rdata);
        end else begin
          ex = exp_q.pop_front();
          chk("mon", "rsp_rdata", 64'(cur.rdata), 64'(ex.rdata));
          chk("mon", "rsp_err", 64'(cur.err), 64'(ex.err));
          chk("mon", "rsp_timeout", 64'(cur.timeout), 64'(ex.timeout));
        end
        held_vld = 1'b0;
      end else begin
        held     = cur;
        held_vld = 1'b1;
      end
    end else begin
      held_vld = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic do_cmd(input string tag, input logic [15:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int wait_n, input bit hang, input logic [31:0] rdata,
                        input bit err, input int acc_exp, input logic [31:0] exp_rdata,
                        input bit exp_err, input bit exp_tmo, input int stall,
                        input bit keep_valid);
    int k;
    int psel_n;
    int pen_n;
    int bad;
    int resp_k;
    int sbad;
    apb_rsp_t ex;
    slv_wait  = wait_n;
    slv_hang  = hang;
    slv_rdata = rdata;
    slv_err   = err;
    ex = {exp_rdata, exp_err, exp_tmo};
    exp_q.push_back(ex);
    rsp_ready = (stall == 0);
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge sys_clk);
      k++;
    end
    chk(tag, "accept", 64'(cmd_ready), 64'(1));
    psel_n = 0;
    pen_n  = 0;
    bad    = 0;
    resp_k = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge sys_clk);
      if (i == 1) begin
        cmd_valid = keep_valid;
        chk(tag, "setup_psel_pen_rdy", 64'({psel, penable, cmd_ready}), 64'(3'b100));
      end
      if (rsp_valid) begin
        resp_k = i;
        break;
      end
      if (psel) psel_n++;
      if (penable) pen_n++;
      if (psel && (paddr !== addr || pwrite !== wr || pwdata !== (wr ? wdata : 32'h0) ||
                   pstrb !== (wr ? strb : 4'h0))) bad++;
      if (cmd_ready) bad++;
    end
    chk(tag, "psel_cycles", 64'(psel_n), 64'(acc_exp + 1));
    chk(tag, "penable_cycles", 64'(pen_n), 64'(acc_exp));
    chk(tag, "rsp_latency", 64'(resp_k), 64'(acc_exp + 2));
    chk(tag, "bus_fields", 64'(bad), 64'(0));
    chk(tag, "resp_bus_idle", 64'({psel, penable, cmd_ready}), 64'(0));
    if (stall > 0) begin
      sbad = 0;
      repeat (stall - 1) begin
        @(negedge sys_clk);
        if (cmd_ready || psel || !rsp_valid) sbad++;
      end
      chk(tag, "stall_hold", 64'(sbad), 64'(0));
      rsp_ready = 1'b1;
    end
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    chk(tag, "post_hs_vld_rdy", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
  endtask

  initial begin : stim
    int k;
    int rbad;
    @(negedge sys_clk);
    #1;
    chk("reset", "ctrl", 64'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, pwrite, psel,
                              penable, pstrb}), 64'(0));
    chk("reset", "paddr_rdata", 64'({paddr, rsp_rdata}), 64'(0));
    chk("reset", "pwdata", 64'(pwdata), 64'(0));
    @(negedge sys_clk);
    rst = 1'b0;

    do_cmd("wr0", 16'h0004, 1'b1, 32'hA5A5_0F0F, 4'hF, 0, 1'b0, 32'h5555_AAAA, 1'b0,
           1, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    do_cmd("rd3", 16'h0000, 1'b0, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b0,
           4, 32'h1234_5678, 1'b0, 1'b0, 0, 1'b0);
    do_cmd("wrerr", 16'h0010, 1'b1, 32'h0BAD_F00D, 4'h3, 1, 1'b0, 32'h7777_7777, 1'b1,
           2, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    do_cmd("rderr", 16'h0020, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_BABE, 1'b1,
           1, 32'hCAFE_BABE, 1'b1, 1'b0, 0, 1'b0);
    do_cmd("stall", 16'h0008, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'h0F0F_1234, 1'b0,
           3, 32'h0F0F_1234, 1'b0, 1'b0, 10, 1'b1);
`ifdef APB_TIMEOUT_EN
    do_cmd("tmo", 16'h0030, 1'b0, 32'h0, 4'h0, 0, 1'b1, 32'h600D_D00D, 1'b0,
           TMO, 32'h0, 1'b1, 1'b1, 0, 1'b0);
`else
    do_cmd("longwait", 16'h0030, 1'b0, 32'h0, 4'h0, 20, 1'b0, 32'h600D_D00D, 1'b0,
           21, 32'h600D_D00D, 1'b0, 1'b0, 0, 1'b0);
`endif

    // Reset in the middle of ACCESS against a hung slave.
    slv_hang  = 1'b1;
    cmd_addr  = 16'h0040;
    cmd_write = 1'b1;
    cmd_wdata = 32'h1111_2222;
    cmd_strb  = 4'hC;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge sys_clk);
      k++;
    end
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("midrst", "in_access", 64'({psel, penable}), 64'(2'b11));
    rst = 1'b1;
    #1;
    chk("midrst", "bus_dropped", 64'({psel, penable, rsp_valid, cmd_ready}), 64'(0));
    chk("midrst", "paddr_pwdata", 64'({paddr, pwdata}), 64'(0));
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    rbad = 0;
    k = 0;
    while (!cmd_ready && k < 5) begin
      @(negedge sys_clk);
      if (rsp_valid || psel) rbad++;
      k++;
    end
    chk("midrst", "ready_back", 64'(cmd_ready), 64'(1));
    chk("midrst", "no_rsp_no_bus", 64'(rbad), 64'(0));

    do_cmd("afterrst", 16'h0044, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h89AB_CDEF, 1'b0,
           1, 32'h89AB_CDEF, 1'b0, 1'b0, 0, 1'b0);

    repeat (2) @(negedge sys_clk);
    chk("end", "scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles to wait for pready (range 1..65535).
REQ-002 SHALL have clock and reset as decided: one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port sys_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have command ports:
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted
- cmd_addr  in  16  byte address
- cmd_write  in  1  1=write, 0=read
- cmd_wdata  in  32  write data
- cmd_strb  in  4  write byte strobes
REQ-006 SHALL have response ports:
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  timeout abort
REQ-007 SHALL have APB4 requester ports:
- paddr  out  16
- pwrite  out  1
- psel  out  1
- penable  out  1
- pstrb  out  4
- pwdata  out  32
- prdata  in  32
- pready  in  1
- pslverr  in  1

Function
REQ-008 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered or decoded from state only.
REQ-009 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, capture the command and go to SETUP.
REQ-010 SHALL drive psel=1 and penable=0 in SETUP for exactly one cycle, then go to ACCESS.
REQ-011 SHALL drive psel=1 and penable=1 in ACCESS; paddr, pwrite, pwdata and pstrb stable from SETUP through the last ACCESS cycle.
REQ-012 SHALL drive pstrb=0 and pwdata=0 for reads.
REQ-013 SHALL, in an ACCESS cycle with pready=1, capture rsp_rdata=prdata for reads (0 for writes) and rsp_err=pslverr, then go to RESP.
REQ-014 SHALL give zero-wait latency: command accepted in cycle N, SETUP N+1, ACCESS N+2, rsp_valid high N+3.
REQ-015 SHALL hold rsp_valid=1 and response fields stable in RESP until rsp_ready=1, then return to IDLE; next cmd_ready earliest the following cycle.
REQ-016 SHALL keep psel=0 and penable=0 in IDLE and RESP; no back-to-back APB transfers without IDLE.
REQ-017 SHALL ignore pready, pslverr and prdata outside ACCESS.
REQ-018 SHALL never have more than one outstanding command.

Reset
REQ-019 SHALL, on rst, force IDLE and all outputs to 0, except cmd_ready=1 after rst deasserts.
REQ-020 SHALL, on rst asserted mid-transaction, drop psel/penable immediately and discard the command with no response.

Configuration
REQ-021 SHALL, with APB_TIMEOUT_EN defined, count consecutive ACCESS cycles with pready=0 using a 16-bit counter cleared on ACCESS entry.
REQ-022 SHALL, when that count reaches TIMEOUT_CYCLES, exit ACCESS and deassert psel/penable next cycle, then enter RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-023 SHALL, when pready=1 in the same cycle the count reaches TIMEOUT_CYCLES, complete normally per REQ-013 with rsp_timeout=0.
REQ-024 SHALL, without APB_TIMEOUT_EN, wait in ACCESS indefinitely, include no counter, and tie rsp_timeout to 0.

Structure
REQ-025 SHALL take from package apb_pkg: APB_ADDR_W=16, APB_DATA_W=32, APB_STRB_W=4, the state enum apb_state_e, and packed structs apb_cmd_t and apb_rsp_t.
REQ-026 SHALL be a single module with no sub-module; apb_pkg is shared with the APB slave blocks.

Verification
REQ-027 Write 0x0004, data 0xA5A5_0F0F, strb 0xF, zero-wait slave -> psel high cycles N+1..N+2, penable high N+2, rsp_valid at N+3, rsp_err=0.
REQ-028 Read 0x0000, slave 3 wait states returning 0x1234_5678 -> addr held 5 cycles, rsp_rdata=0x1234_5678, pstrb=0 throughout.
REQ-029 Write with pslverr=1 on the pready cycle -> rsp_err=1, rsp_timeout=0.
REQ-030 APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready tied 0 -> psel drops after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-031 rsp_ready held 0 for 10 cycles while cmd_valid=1 -> cmd_ready stays 0, response stable, new command accepted only after handshake.
REQ-032 rst pulsed during ACCESS -> psel/penable 0 at once, no rsp_valid, next command completes correctly.
